// File: rtl/p2s_pkg.sv
// Shared definitions for the serial link: FSM encoding, default widths and
// the frame-length decode used by both the transmitter and the receiver.
package p2s_pkg;

   localparam int P2S_WIDTH = 16;
   localparam int P2S_LEN_W = 4;
   localparam int P2S_CNT_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } p2s_state_e;

   // A len of 0 encodes a full 16-bit frame; the 5-bit result makes 16 representable.
   function automatic logic [P2S_CNT_W-1:0] p2s_frame_len(input logic [P2S_LEN_W-1:0] len_val);
      return (len_val == '0) ? P2S_CNT_W'(P2S_WIDTH) : P2S_CNT_W'(len_val);
   endfunction

endpackage

// File: rtl/p2s_if.sv
// Start/busy/done request bus plus the serial link outputs of p2s_tx.
interface p2s_if;
   import p2s_pkg::*;

   // start is a level sampled on the rising edge and is accepted only while
   // busy=0; a start seen while busy=1 (DONE cycle included) is dropped, not
   // queued. data_in/len are captured at acceptance. done pulses for one cycle
   // after the last bit, with busy still high in that cycle.
   logic                 start;
   logic [P2S_WIDTH-1:0] data_in;
   logic [P2S_LEN_W-1:0] len;
   logic                 serial_out;
   logic                 shift_en;
   logic                 busy;
   logic                 done;

   modport master (output start, data_in, len,
                   input  serial_out, shift_en, busy, done);

   modport slave  (input  start, data_in, len,
                   output serial_out, shift_en, busy, done);

endinterface

// File: rtl/p2s_tick.sv
// Bit-period divider: counts 0..DIV-1 while running and flags the last cycle.
module p2s_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   // With DIV=1 the counter never leaves 0, so tick is constantly high.
   assign tick = (cnt == LAST);

endmodule

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: latches a 1..16-bit word and shifts it out
// MSB-first with a one-cycle strobe at the end of each bit period.
module p2s_tx
   import p2s_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   p2s_if.slave       bus,
   output p2s_state_e state_dbg
);

   p2s_state_e             state, state_nx;
   logic [P2S_WIDTH-1:0]   shreg;
   logic [P2S_CNT_W-1:0]   count;
   logic [P2S_CNT_W-1:0]   count_inc;
   logic [P2S_CNT_W-1:0]   n_q;
   logic [P2S_CNT_W-1:0]   n_dec;
   logic                   accept;
   logic                   tick;
   logic                   in_shift;

   assign n_dec     = p2s_frame_len(bus.len);
   assign accept    = (state == ST_IDLE) && bus.start;
   assign in_shift  = (state == ST_SHIFT);
   assign count_inc = count + 1'b1;

   p2s_tick #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .run   (in_shift),
      .tick  (tick)
   );

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (bus.start) state_nx = ST_SHIFT;
         ST_SHIFT: if (tick && (count_inc == n_q)) state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         shreg <= '0;
         count <= '0;
         n_q   <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            // Left-align the N-bit field so the MSB to send sits in shreg[15];
            // after N shifts the register is all zeros again.
            shreg <= bus.data_in << (P2S_CNT_W'(P2S_WIDTH) - n_dec);
            n_q   <= n_dec;
            count <= '0;
         end else if (in_shift && tick) begin
            shreg <= shreg << 1;
            count <= count_inc;
         end
      end
   end

   assign bus.serial_out = shreg[P2S_WIDTH-1];
   assign bus.shift_en   = in_shift && tick;
   assign bus.busy       = (state != ST_IDLE);
   assign bus.done       = (state == ST_DONE);
   assign state_dbg      = state;

endmodule

// File: tb/tb_p2s_tx.sv
// Bench for p2s_tx: DIV=1 and DIV=3 instances, table-driven frames with a
// bit-level scoreboard, plus start-during-busy and mid-frame reset sequences.
module tb_p2s_tx;
   import p2s_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   p2s_if bus_d1 ();
   p2s_if bus_d3 ();
   p2s_state_e state_d1, state_d3;

   p2s_tx #(.DIV(1)) dut_d1 (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus_d1.slave),
      .state_dbg (state_d1)
   );

   p2s_tx #(.DIV(3)) dut_d3 (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus_d3.slave),
      .state_dbg (state_d3)
   );

   typedef struct {
      int          sel;
      logic [15:0] data;
      logic [3:0]  len;
      logic [15:0] exp_word;
      int          exp_n;
      int          exp_done;
   } vec_t;

   vec_t        vecs[7];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [0:0]  exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // {serial_out, shift_en, busy, done}
   function automatic logic [3:0] outs(input int sel);
      if (sel == 0) return {bus_d1.serial_out, bus_d1.shift_en, bus_d1.busy, bus_d1.done};
      return {bus_d3.serial_out, bus_d3.shift_en, bus_d3.busy, bus_d3.done};
   endfunction

   task automatic drive(input int sel, input logic s, input logic [15:0] d, input logic [3:0] l);
      if (sel == 0) begin
         bus_d1.start = s; bus_d1.data_in = d; bus_d1.len = l;
      end else begin
         bus_d3.start = s; bus_d3.data_in = d; bus_d3.len = l;
      end
   endtask

   task automatic start_frame(input int sel, input logic [15:0] d, input logic [3:0] l);
      @(negedge clk);
      drive(sel, 1'b1, d, l);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, d, l);
   endtask

   task automatic push_frame(input logic [15:0] w, input int n);
      for (int i = n - 1; i >= 0; i--) exp_q.push_back(w[i]);
   endtask

   task automatic sb_pop(input logic so);
      logic [0:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL sb_underflow: got strobe with bit %0b, expected no strobe", so);
      end else begin
         e = exp_q.pop_front();
         chk("sb_bit", 32'(so), 32'(e));
      end
   endtask

   // Samples one frame at falling edges; cycle 1 is the cycle after the accepting edge.
   task automatic capture(input int sel, input int div, output logic [15:0] word,
                          output int nstr, output int done_cyc, output int bad);
      logic [3:0] o;
      logic       prev_so;
      word = '0; nstr = 0; done_cyc = -1; bad = 0; prev_so = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         o = outs(sel);
         if (!o[1]) bad++;
         if (o[0]) begin
            done_cyc = c;
            if (o[3] || o[2]) bad++;
            break;
         end
         if ((((c - 1) % div) != 0) && (o[3] != prev_so)) bad++;
         prev_so = o[3];
         if (o[2]) begin
            nstr++;
            word = {word[14:0], o[3]};
            sb_pop(o[3]);
            if ((c % div) != 0) bad++;
         end else if ((c % div) == 0) begin
            bad++;
         end
      end
   endtask

   task automatic finish_frame(input int sel, input logic [15:0] exp_word,
                               input int exp_n, input int exp_done, input string tag);
      logic [15:0] w;
      int          n, dc, bad;
      capture(sel, (sel == 0) ? 1 : 3, w, n, dc, bad);
      chk({tag, "_word"}, 32'(w), 32'(exp_word));
      chk({tag, "_strobes"}, 32'(n), 32'(exp_n));
      chk({tag, "_done_cycle"}, 32'(dc), 32'(exp_done));
      chk({tag, "_timing_errs"}, 32'(bad), 32'd0);
      chk({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(negedge clk);
      chk({tag, "_idle_after"}, 32'(outs(sel)), 32'd0);
   endtask

   task automatic run_vec(input int sel, input logic [15:0] d, input logic [3:0] l,
                          input logic [15:0] exp_word, input int exp_n, input int exp_done,
                          input string tag);
      start_frame(sel, d, l);
      push_frame(exp_word, exp_n);
      finish_frame(sel, exp_word, exp_n, exp_done, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  o;
      logic [15:0] rd, rw;
      logic [3:0]  rl;
      int          rn;

      vecs[0] = '{0, 16'hA5C3, 4'd0,  16'hA5C3, 16, 17};
      vecs[1] = '{0, 16'h12F0, 4'd8,  16'h00F0,  8,  9};
      vecs[2] = '{1, 16'h0009, 4'd4,  16'h0009,  4, 13};
      vecs[3] = '{0, 16'h0001, 4'd1,  16'h0001,  1,  2};
      vecs[4] = '{0, 16'hFFFF, 4'd15, 16'h7FFF, 15, 16};
      vecs[5] = '{1, 16'hBEEF, 4'd0,  16'hBEEF, 16, 49};
      vecs[6] = '{1, 16'h8001, 4'd2,  16'h0001,  2,  7};

      // Reset held with start asserted on a full-ones word.
      drive(0, 1'b1, 16'hFFFF, 4'd0);
      drive(1, 1'b1, 16'hFFFF, 4'd0);
      repeat (3) @(negedge clk);
      chk("rst_outs_d1", 32'(outs(0)), 32'd0);
      chk("rst_outs_d3", 32'(outs(1)), 32'd0);
      chk("rst_state_d1", 32'(state_d1), 32'(ST_IDLE));
      chk("rst_state_d3", 32'(state_d3), 32'(ST_IDLE));
      drive(0, 1'b0, 16'h0000, 4'd0);
      drive(1, 1'b0, 16'h0000, 4'd0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_idle_d1", 32'(outs(0)), 32'd0);
      chk("post_rst_idle_d3", 32'(outs(1)), 32'd0);

      for (int i = 0; i < 7; i++)
         run_vec(vecs[i].sel, vecs[i].data, vecs[i].len, vecs[i].exp_word,
                 vecs[i].exp_n, vecs[i].exp_done, $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         rd = 16'($urandom_range(0, 16'hFFFF));
         rl = 4'($urandom_range(0, 15));
         rn = (rl == 4'd0) ? 16 : int'(rl);
         rw = rd & 16'((32'd1 << rn) - 1);
         run_vec((i < 4) ? 0 : 1, rd, rl, rw, rn, (i < 4) ? rn + 1 : rn * 3 + 1,
                 $sformatf("rnd%0d", i));
      end

      // len=1 frame with start held high through the busy cycles.
      @(negedge clk);
      drive(0, 1'b1, 16'h0001, 4'd1);
      @(posedge clk);
      #1;
      drive(0, 1'b1, 16'h0003, 4'd2);
      push_frame(16'h0001, 1);
      @(negedge clk);
      o = outs(0);
      chk("a_c1_outs", 32'(o), 32'(4'b1110));
      chk("a_c1_state", 32'(state_d1), 32'(ST_SHIFT));
      sb_pop(o[3]);
      @(negedge clk);
      chk("a_c2_outs", 32'(outs(0)), 32'(4'b0011));
      chk("a_c2_state", 32'(state_d1), 32'(ST_DONE));
      @(negedge clk);
      chk("a_c3_outs", 32'(outs(0)), 32'd0);
      chk("a_c3_state", 32'(state_d1), 32'(ST_IDLE));
      @(posedge clk);
      #1;
      drive(0, 1'b0, 16'h0000, 4'd0);
      push_frame(16'h0003, 2);
      finish_frame(0, 16'h0003, 2, 3, "a_second");

      // Reset mid-frame, then a clean frame afterwards.
      start_frame(0, 16'hA5C3, 4'd0);
      repeat (5) @(negedge clk);
      chk("b_mid_busy", 32'(outs(0) & 4'b0010), 32'(4'b0010));
      #2;
      reset = 1'b0;
      #1;
      chk("b_async_clear", 32'(outs(0)), 32'd0);
      chk("b_async_state", 32'(state_d1), 32'(ST_IDLE));
      repeat (2) begin
         @(negedge clk);
         chk("b_in_reset", 32'(outs(0)), 32'd0);
      end
      reset = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      chk("b_no_done", 32'(outs(0)), 32'd0);
      run_vec(0, 16'h00FF, 4'd0, 16'h00FF, 16, 17, "b_after");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
